spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 40 ++++
 rtl/spi_shift_reg.sv | 35 +++
 rtl/spi_master.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM states, opcodes, widths
// and the frame word layout.
package spi_pkg;

    localparam int unsigned WORD_W = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [OP_W-1:0] WR_ADDR = 2'b00;
    localparam logic [OP_W-1:0] WR_DATA = 2'b01;
    localparam logic [OP_W-1:0] RD_ADDR = 2'b10;
    localparam logic [OP_W-1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        SHIFT,
        TURN,
        CAPTURE,
        END
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] payload;
    } frame_t;

    // Only rd-data frames turn the bus around and capture a MISO byte.
    function automatic logic is_rd_data(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            WR_ADDR, WR_DATA, RD_ADDR: r = 1'b0;
            RD_DATA:                   r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register, MSB first; shifts data out of the top bit and
// serial data into the bottom bit on the same step.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int unsigned W     = WORD_W,
    parameter int unsigned CAP_W = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             shift,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [CAP_W-1:0] capture_c
);

    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[W-2:0], serial_in};
        end
    end

    assign serial_out = q[W-1];
    // Low bits as they will look after this cycle's shift.
    assign capture_c  = {q[CAP_W-2:0], serial_in};

endmodule

// File: rtl/spi_master.sv
// SPI frame master: shifts out a 10-bit command word and, on rd-data frames,
// turns the bus around and captures one MISO byte.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] tx_word,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int unsigned TURN_LAST = (TURN_CYCLES == 0) ? 0 : TURN_CYCLES - 1;
    localparam logic [CNT_W-1:0] SHIFT_END = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CAP_END   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] TURN_END  = CNT_W'(TURN_LAST);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    frame_t            frame_c;
    logic              sr_load_c;
    logic              sr_shift_c;
    logic              sr_in_c;
    logic              sr_out;
    logic [DATA_W-1:0] sr_capture_c;

    assign frame_c = frame_t'(tx_word);
    assign sr_in_c = (state_q == CAPTURE) && MISO;

    spi_shift_reg #(
        .W     (WORD_W),
        .CAP_W (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (sr_load_c),
        .load_data  (frame_c),
        .shift      (sr_shift_c),
        .serial_in  (sr_in_c),
        .serial_out (sr_out),
        .capture_c  (sr_capture_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Next state, shifter control and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sr_load_c  = 1'b0;
        sr_shift_c = 1'b0;
        cnt_d      = cnt_q;
        ss_n_d     = 1'b1;
        mosi_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CMD;
                    sr_load_c = 1'b1;
                    op_d      = frame_c.op;
                end
            end
            CMD: begin
                state_d    = SHIFT;
                sr_shift_c = 1'b1;
            end
            SHIFT: begin
                sr_shift_c = 1'b1;
                if (cnt_q == SHIFT_END) begin
                    if (!is_rd_data(op_q)) begin
                        state_d = END;
                    end else if (TURN_CYCLES == 0) begin
                        state_d = CAPTURE;
                    end else begin
                        state_d = TURN;
                    end
                end
            end
            TURN: begin
                if (cnt_q == TURN_END) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                sr_shift_c = 1'b1;
                if (cnt_q == CAP_END) begin
                    state_d = END;
                end
            end
            END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counter restarts on every state entry and only runs in multi-cycle states.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == SHIFT || state_q == TURN || state_q == CAPTURE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        ss_n_d = (state_d == IDLE) || (state_d == END);
        busy_d = (state_d != IDLE);
        done_d = (state_d == END);

        // The command bit is driven once in CMD, then the whole word again in SHIFT.
        case (state_d)
            CMD:     mosi_d = frame_c.op[OP_W-1];
            SHIFT:   mosi_d = sr_out;
            default: mosi_d = 1'b0;
        endcase

        if (state_d == END && is_rd_data(op_q)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = sr_capture_c;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign SS_n     = ss_n_q;
    assign MOSI     = mosi_q;

endmodule
